// File: rtl/uart_pkg.sv
// Shared UART receive definitions: framer states, baud timing constants, data width default.
package uart_pkg;

  localparam int BPS_PERIOD    = 2083;
  localparam int BPS_HALF      = 1041;
  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// rx synchroniser (SYNC_STAGES flops, reset to idle-high) plus falling-edge detect on the synchronised line.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rx_s = r_sync[SYNC_STAGES-1];
  assign o_fall = r_prev & ~o_rx_s;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, mid-bit sampling on bps_clk, LSB-first assembly, valid/ready holding register.
// Defining UART_RX_PARITY_EN adds a parity bit (PARITY_ODD selects odd) and a parity_err pulse.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD  = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  input  logic                 bps_clk,
  output logic                 count_sig,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int                CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_fall;
  rx_state_e            r_state;
  rx_state_e            w_next;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_count_sig;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_par_bad;
  logic                 w_run;
  logic                 w_shift_en;
  logic                 w_good_stop;
  logic                 w_bad_stop;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .i_rx   (rx),
    .o_rx_s (w_rx_s),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk) begin
    if (rstn) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_fall)  w_next = ST_START;
      ST_START: if (bps_clk) w_next = w_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (bps_clk && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (bps_clk) w_next = ST_STOP;
`endif
      ST_STOP:  if (bps_clk) w_next = w_rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (w_rx_s)  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // count_sig follows the next state so it rises with START entry and falls right after the stop sample.
  always_comb begin
    w_run       = (w_next == ST_START) || (w_next == ST_DATA) ||
                  (w_next == ST_PARITY) || (w_next == ST_STOP);
    w_shift_en  = (r_state == ST_DATA) && bps_clk;
    w_good_stop = (r_state == ST_STOP) && bps_clk && w_rx_s && !r_par_bad;
    w_bad_stop  = (r_state == ST_STOP) && bps_clk && !w_rx_s;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_count_sig <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_count_sig <= w_run;
      r_frame_err <= w_bad_stop;
      r_overrun   <= w_good_stop && r_valid && !rx_ready;
      if ((r_state == ST_START) && bps_clk) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end
      if (w_good_stop && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_parity_err;
  logic w_par_mismatch;

  assign w_par_mismatch = ((^r_shift) ^ w_rx_s) != PARITY_ODD;

  // r_par_bad is rewritten by every frame's parity sample before its stop sample.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      if ((r_state == ST_PARITY) && bps_clk) begin
        r_par_bad    <= w_par_mismatch;
        r_parity_err <= w_par_mismatch;
      end
    end
  end

  assign parity_err = r_parity_err;
`else
  assign r_par_bad = 1'b0;
`endif

  assign count_sig = r_count_sig;
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame with a behavioural baud generator (shortened bit period) and a byte-queue reference model.
module tb_uart_rx_frame;

  localparam int P = 105;
  localparam int H = 52;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic       bps_clk;
  logic       rx_ready;
  logic       count_sig;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_frame #(
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .bps_clk    (bps_clk),
    .count_sig  (count_sig),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Baud generator: first strobe H+1 cycles after count_sig rises, then every P cycles.
  int unsigned r_bcnt = 0;
  always @(posedge clk) begin
    if (!count_sig)          r_bcnt <= 0;
    else if (r_bcnt == P-1)  r_bcnt <= 0;
    else                     r_bcnt <= r_bcnt + 1;
  end
  assign bps_clk = count_sig && (r_bcnt == H);

  // Monitor: collect accepted bytes and pulse counts on the falling edge.
  logic [7:0] obs_q[$];
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         n_valid_cyc = 0;
  int         n_hold_bad = 0;
  logic       held_vld = 1'b0;
  logic [7:0] held_dat = 8'h00;

  always @(negedge clk) begin
    if (held_vld && rx_valid && (rx_data !== held_dat)) n_hold_bad++;
    if (rx_valid === 1'b1) n_valid_cyc++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) obs_q.push_back(rx_data);
    if (frame_err === 1'b1) n_ferr++;
    if (overrun === 1'b1) n_ovr++;
    held_vld = (rx_valid === 1'b1) && (rx_ready === 1'b0);
    held_dat = rx_data;
  end

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         chk_idx = 0;
  int         exp_ferr = 0;
  int         exp_ovr = 0;
  bit         rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = chk_idx; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk({tag, "_byte"}, obs_q[i], exp_q[i]);
    chk_idx = exp_q.size();
    chk({tag, "_frame_err"}, n_ferr, exp_ferr);
    chk({tag, "_overrun"}, n_ovr, exp_ovr);
  endtask

  task automatic bit_time(input logic v, input int n);
    rx = v;
    for (int c = 0; c < n; c++) begin
      if (rand_rdy) rx_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_body(input logic [7:0] d);
    bit_time(1'b0, P);
    for (int i = 0; i < 8; i++) bit_time(d[i], P);
`ifdef UART_RX_PARITY_EN
    bit_time(^d, P);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_body(d);
    bit_time(1'b1, P);
  endtask

  initial begin
    int v0;
    logic [7:0] d;
    rx = 1'b1;
    rx_ready = 1'b1;
    rstn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_count_sig", count_sig, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    rstn = 1'b0;
    bit_time(1'b1, 2*P);

    // Single 0x55 frame.
    v0 = n_valid_cyc;
    send_frame(8'h55);
    exp_q.push_back(8'h55);
    chk("b55_count_sig_low", count_sig, 0);
    bit_time(1'b1, P);
    chk("b55_valid_cycles", n_valid_cyc - v0, 1);
    check_model("b55");

    // Short low glitch: false start.
    bit_time(1'b0, 25);
    chk("glitch_count_sig_up", count_sig, 1);
    bit_time(1'b1, P);
    chk("glitch_count_sig_down", count_sig, 0);
    check_model("glitch");

    // 0xA3 with stop held low three bit times, then 0x0F.
    send_body(8'hA3);
    bit_time(1'b0, P);
    chk("brk_count_sig", count_sig, 0);
    chk("brk_rx_valid", rx_valid, 0);
    bit_time(1'b0, 2*P);
    exp_ferr++;
    chk("brk_still_low", count_sig, 0);
    bit_time(1'b1, P);
    send_frame(8'h0F);
    exp_q.push_back(8'h0F);
    bit_time(1'b1, P);
    check_model("brk");

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    send_frame(8'h12);
    bit_time(1'b1, P);
    send_frame(8'h34);
    bit_time(1'b1, P);
    exp_ovr++;
    chk("ovr_valid_held", rx_valid, 1);
    chk("ovr_data_held", rx_data, 8'h12);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    chk("ovr_valid_clear", rx_valid, 0);
    exp_q.push_back(8'h12);
    bit_time(1'b1, P);
    check_model("ovr");

    // Back-to-back with a one-bit idle gap.
    send_frame(8'h00); bit_time(1'b1, P);
    send_frame(8'hFF); bit_time(1'b1, P);
    send_frame(8'h81); bit_time(1'b1, P);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    check_model("b2b");

    // Reset during data bit 4 of 0xC6; sender aborts with the receiver.
    d = 8'hC6;
    bit_time(1'b0, P);
    for (int i = 0; i < 4; i++) bit_time(d[i], P);
    bit_time(d[4], 50);
    chk("mrst_in_frame", count_sig, 1);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("mrst_count_sig", count_sig, 0);
    chk("mrst_rx_data", rx_data, 0);
    chk("mrst_rx_valid", rx_valid, 0);
    rstn = 1'b0;
    bit_time(1'b1, 2*P);
    send_frame(8'h3C);
    exp_q.push_back(8'h3C);
    bit_time(1'b1, P);
    check_model("mrst");

    // Randomised frames, gaps, stop-bit errors and consumer readiness.
    rand_rdy = 1'b1;
    for (int f = 0; f < 12; f++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        send_body(d);
        bit_time(1'b0, P * $urandom_range(1, 2));
        bit_time(1'b1, P);
        exp_ferr++;
      end else begin
        send_frame(d);
        exp_q.push_back(d);
      end
      bit_time(1'b1, $urandom_range(1, 2*P));
    end
    rand_rdy = 1'b0;
    rx_ready = 1'b1;
    bit_time(1'b1, P);
    check_model("rand");

    chk("hold_stable", n_hold_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
